// File: rtl/blake2_host_drv_pkg.sv
// rtl/blake2_host_drv_pkg.sv - shared encodings and constants for the BLAKE2s host driver
package blake2_pkg;

    typedef enum logic [1:0] {
        CMD_CONF  = 2'b00,
        CMD_DATA  = 2'b01,
        CMD_LAST  = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_BLOCK,
        ST_GAP,
        ST_WAIT,
        ST_READ
    } host_state_e;

    localparam int BLOCK_BYTES = 64;
    localparam int CONF_BYTES  = 10;
    localparam int MAX_NN      = 32;
    localparam int MAX_KK      = 32;

    // Config frame: kk, nn, then ll little-endian.
    function automatic logic [7:0] conf_byte(input logic [7:0]  kk,
                                             input logic [7:0]  nn,
                                             input logic [63:0] ll,
                                             input logic [5:0]  idx);
        logic [2:0] sh;
        sh = 3'(idx - 6'd2);
        case (idx)
            6'd0:    conf_byte = kk;
            6'd1:    conf_byte = nn;
            default: conf_byte = ll[{sh, 3'b000} +: 8];
        endcase
    endfunction

endpackage

// File: rtl/blake2_host_drv_if.sv
// rtl/blake2_host_drv_if.sv - byte-serial BLAKE2s device bus between host driver and hash core
interface blake2_host_drv_if;
    logic       valid;
    logic [1:0] cmd;
    logic [7:0] data;
    logic       hash_finished;
    logic [7:0] hash;

    modport master (output valid, cmd, data, input hash_finished, hash);
    modport slave  (input valid, cmd, data, output hash_finished, hash);
endinterface

// File: rtl/blake2_host_blkcnt.sv
// rtl/blake2_host_blkcnt.sv - block count and remaining stream bytes for one hash request
module blake2_host_blkcnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [7:0]  kk_i,
    input  logic [63:0] ll_i,
    input  logic        take_i,
    input  logic        blk_done_i,
    output logic        stream_left_o,
    output logic        last_blk_o
);
    logic        key_blk;
    logic [57:0] nblk_raw, nblk, blk_q, blk_d;
    logic [64:0] rem_q, rem_d;

    assign key_blk  = (kk_i != 8'd0);
    assign nblk_raw = ll_i[63:6] + 58'(ll_i[5:0] != 6'd0) + 58'(key_blk);
    // An empty unkeyed message still hashes one all-zero block.
    assign nblk     = (nblk_raw == '0) ? 58'd1 : nblk_raw;

    always_comb begin
        rem_d = rem_q;
        blk_d = blk_q;
        if (load_i) begin
            rem_d = {1'b0, ll_i} + {58'd0, key_blk, 6'd0};
            blk_d = nblk;
        end else begin
            if (take_i && rem_q != '0)
                rem_d = rem_q - 65'd1;
            if (blk_done_i && blk_q != '0)
                blk_d = blk_q - 58'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            blk_q <= '0;
        end else begin
            rem_q <= rem_d;
            blk_q <= blk_d;
        end
    end

    assign stream_left_o = (rem_q != '0);
    assign last_blk_o    = (blk_q == 58'd1);
endmodule

// File: rtl/blake2_host_drv.sv
// rtl/blake2_host_drv.sv - BLAKE2s host transmitter; BLAKE2_HOST_TIMEOUT_EN adds a WAIT_HASH abort
module blake2_host_drv
    import blake2_pkg::*;
#(
    parameter int COMPRESS_GAP   = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_v_i,
    output logic                     req_rdy_o,
    input  logic [7:0]               kk_i,
    input  logic [7:0]               nn_i,
    input  logic [63:0]              ll_i,
    input  logic                     msg_v_i,
    input  logic [7:0]               msg_i,
    output logic                     msg_rdy_o,
    blake2_host_drv_if.master        dev,
    output logic                     res_v_o,
    output logic [7:0]               res_o,
    output logic                     res_last_o,
    output logic                     err_o
);
    host_state_e state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  kk_q, kk_d, nn_q, nn_d, res_q, res_d;
    logic [63:0] ll_q, ll_d;
    logic        blk_load, byte_take, blk_done, advance;
    logic        stream_left, last_blk;

    blake2_host_blkcnt u_blkcnt (
        .clk           (clk),
        .reset         (reset),
        .load_i        (blk_load),
        .kk_i          (kk_i),
        .ll_i          (ll_i),
        .take_i        (byte_take),
        .blk_done_i    (blk_done),
        .stream_left_o (stream_left),
        .last_blk_o    (last_blk)
    );

`ifdef BLAKE2_HOST_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        err_q, err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == ST_WAIT) ? tmo_q + 32'd1 : '0;
            if (err_set)
                err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign err_o      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        kk_d       = kk_q;
        nn_d       = nn_q;
        ll_d       = ll_q;
        res_d      = res_q;
        blk_load   = 1'b0;
        byte_take  = 1'b0;
        blk_done   = 1'b0;
        advance    = 1'b0;
        req_rdy_o  = 1'b0;
        msg_rdy_o  = 1'b0;
        dev.valid  = 1'b0;
        dev.cmd    = CMD_CONF;
        dev.data   = 8'h00;
        res_v_o    = 1'b0;
        res_last_o = 1'b0;
`ifdef BLAKE2_HOST_TIMEOUT_EN
        err_set    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_rdy_o = 1'b1;
                if (req_v_i) begin
                    kk_d     = kk_i;
                    nn_d     = nn_i;
                    ll_d     = ll_i;
                    blk_load = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_CONF;
                end
            end
            ST_CONF: begin
                dev.valid = 1'b1;
                dev.data  = conf_byte(kk_q, nn_q, ll_q, idx_q);
                idx_d     = idx_q + 6'd1;
                if (idx_q == 6'(CONF_BYTES - 1)) begin
                    idx_d   = '0;
                    state_d = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                dev.cmd = last_blk ? CMD_LAST : CMD_DATA;
                if (stream_left) begin
                    msg_rdy_o = 1'b1;
                    dev.valid = msg_v_i;
                    dev.data  = msg_i;
                    advance   = msg_v_i;
                    byte_take = msg_v_i;
                end else begin
                    dev.valid = 1'b1;
                    advance   = 1'b1;
                end
                if (advance) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'(BLOCK_BYTES - 1)) begin
                        blk_done = 1'b1;
                        gap_d    = '0;
                        state_d  = last_blk ? ST_WAIT : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == 16'(COMPRESS_GAP - 1))
                    state_d = ST_BLOCK;
            end
            ST_WAIT: begin
                // Digest byte 0 is already on hash in the cycle finished rises.
                if (dev.hash_finished) begin
                    res_d   = dev.hash;
                    idx_d   = '0;
                    state_d = ST_READ;
                end
`ifdef BLAKE2_HOST_TIMEOUT_EN
                else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    dev.valid = 1'b1;
                    dev.cmd   = CMD_ABORT;
                    err_set   = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_READ: begin
                res_v_o = 1'b1;
                res_d   = dev.hash;
                idx_d   = idx_q + 6'd1;
                if (({2'b00, idx_q} + 8'd1) >= nn_q) begin
                    res_last_o = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            kk_q    <= '0;
            nn_q    <= '0;
            ll_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            kk_q    <= kk_d;
            nn_q    <= nn_d;
            ll_q    <= ll_d;
            res_q   <= res_d;
        end
    end

    assign res_o = res_v_o ? res_q : 8'h00;
endmodule

// File: tb/tb_blake2_host_drv.sv
// tb/tb_blake2_host_drv.sv - self-checking bench for blake2_host_drv with a device-side model
module tb_blake2_host_drv;
    localparam int GAP = 24;
    localparam int TMO = 100;
    localparam logic [1:0] C_CONF = 2'b00, C_DATA = 2'b01, C_LAST = 2'b10, C_ABORT = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v, req_rdy, msg_v, msg_rdy, res_v, res_last, err;
    logic [7:0]  kk, nn, msg, res;
    logic [63:0] ll;

    blake2_host_drv_if dev ();

    blake2_host_drv #(.COMPRESS_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_v_i    (req_v),
        .req_rdy_o  (req_rdy),
        .kk_i       (kk),
        .nn_i       (nn),
        .ll_i       (ll),
        .msg_v_i    (msg_v),
        .msg_i      (msg),
        .msg_rdy_o  (msg_rdy),
        .dev        (dev),
        .res_v_o    (res_v),
        .res_o      (res),
        .res_last_o (res_last),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    logic [7:0]  stream[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  got[$];
    int          got_t[$];
    logic [7:0]  got_res[$];
    int          last_idx[$];
    logic [7:0]  dig[32];
    longint      exp_total;
    int          consumed, mirror_bad, abort_cnt, abort_wc;
    bit          txn_done;

    task automatic make_stream(input logic [7:0] k, input logic [63:0] l);
        stream.delete();
        if (k != 0)
            for (int i = 0; i < 64; i++) stream.push_back(i < k ? 8'($urandom_range(255, 1)) : 8'h00);
        for (longint i = 0; i < longint'(l); i++) stream.push_back(8'($urandom));
    endtask

    // Expected device-bus byte list built from the frame rules, independent of any timing.
    task automatic build_exp(input logic [7:0] k, input logic [7:0] n, input logic [63:0] l);
        longint nb, pos;
        exp_q.delete();
        exp_q.push_back({C_CONF, k});
        exp_q.push_back({C_CONF, n});
        for (int j = 0; j < 8; j++) exp_q.push_back({C_CONF, l[8*j +: 8]});
        exp_total = longint'(l) + ((k != 0) ? 64 : 0);
        nb = (exp_total + 63) / 64;
        if (nb == 0) nb = 1;
        for (longint b = 0; b < nb; b++)
            for (int i = 0; i < 64; i++) begin
                pos = b * 64 + i;
                exp_q.push_back({(b == nb - 1) ? C_LAST : C_DATA, (pos < exp_total) ? stream[pos] : 8'h00});
            end
    endtask

    task automatic run_txn(input logic [7:0] k, input logic [7:0] n, input logic [63:0] l,
                           input int mode, input int fin_delay);
        int sp, lastc, wc, hk;
        bit in_wait, done;
        sp = 0; lastc = 0; wc = 0; hk = 0; in_wait = 0; done = 0;
        got.delete(); got_t.delete(); got_res.delete(); last_idx.delete();
        mirror_bad = 0; abort_cnt = 0; abort_wc = -1;
        for (int i = 0; i < 32; i++) dig[i] = 8'($urandom);
        @(posedge clk); #1;
        req_v = 1'b1; kk = k; nn = n; ll = l; msg_v = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (dev.valid) begin
                got.push_back({dev.cmd, dev.data});
                got_t.push_back(c);
                if (dev.cmd == C_LAST) lastc++;
                if (dev.cmd == C_ABORT) begin abort_cnt++; abort_wc = wc; done = 1; end
            end
            if (msg_rdy && (dev.valid !== msg_v)) mirror_bad++;
            if (msg_v && msg_rdy) sp++;
            if (res_v) begin
                got_res.push_back(res);
                if (res_last) begin last_idx.push_back(got_res.size() - 1); done = 1; end
            end
            if (lastc == 64) in_wait = 1;
            @(posedge clk); #1;
            req_v = 1'b0;
            if (in_wait) begin
                wc++;
                if (wc >= fin_delay) begin
                    dev.hash_finished = 1'b1;
                    dev.hash = (hk < 32) ? dig[hk] : 8'($urandom);
                    hk++;
                end
            end
            msg_v = (sp < stream.size()) &&
                    (mode == 0 || (mode == 1 && c[0]) || (mode == 2 && $urandom_range(1, 0) == 1));
            msg = (sp < stream.size()) ? stream[sp] : 8'($urandom);
        end
        txn_done = done; consumed = sp;
        dev.hash_finished = 1'b0; dev.hash = 8'h00; msg_v = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_rdy, msg_rdy, dev.valid, dev.cmd, dev.data, res_v, res, res_last, err} !== 24'h800000)
            begin failures++; $display("FAIL reset_held: got %h expected 800000",
                {req_rdy, msg_rdy, dev.valid, dev.cmd, dev.data, res_v, res, res_last, err}); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_rdy, msg_rdy, dev.valid, res_v, err} !== 5'b10000)
            begin failures++; $display("FAIL reset_idle: got %b expected 10000", {req_rdy, msg_rdy, dev.valid, res_v, err}); end
    endtask

    task automatic test_stream();
        logic [7:0]  k, n;
        logic [63:0] l;
        int          mode, np;
        np = 0;
        for (int t = 0; t < 11; t++) begin
            case (t)
                0: begin k = 0;  n = 32; l = 3;   mode = 0; end
                1: begin k = 0;  n = 32; l = 0;   mode = 0; end
                2: begin k = 0;  n = 32; l = 128; mode = 0; end
                3: begin k = 16; n = 16; l = 65;  mode = 0; end
                4: begin k = 0;  n = 8;  l = 100; mode = 1; end
                default: begin
                    k = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(32, 1)) : 8'd0;
                    n = 8'($urandom_range(32, 1)); l = 64'($urandom_range(200, 0)); mode = $urandom_range(2, 0);
                end
            endcase
            make_stream(k, l);
            if (t == 0) begin stream[0] = 8'h61; stream[1] = 8'h62; stream[2] = 8'h63; end
            build_exp(k, n, l);
            run_txn(k, n, l, mode, $urandom_range(6, 1));
            checks++;
            if (txn_done !== 1'b1) begin failures++; $display("FAIL stream_done case %0d: got 0 expected 1", t); end
            checks++;
            if (got.size() != exp_q.size())
                begin failures++; $display("FAIL stream_len case %0d: got %0d expected %0d", t, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    failures++;
                    if (np++ < 20) $display("FAIL stream_byte case %0d idx %0d: got %h expected %h", t, i, got[i], exp_q[i]);
                end
            end
            checks++;
            if (consumed != exp_total)
                begin failures++; $display("FAIL consumed case %0d: got %0d expected %0d", t, consumed, exp_total); end
            checks++;
            if (mirror_bad != 0) begin failures++; $display("FAIL bubble_mirror case %0d: got %0d expected 0", t, mirror_bad); end
            checks++;
            if (got_res.size() != n) begin failures++; $display("FAIL res_count case %0d: got %0d expected %0d", t, got_res.size(), n); end
            for (int i = 0; i < got_res.size() && i < n; i++) begin
                checks++;
                if (got_res[i] !== dig[i]) begin failures++; $display("FAIL res_byte case %0d idx %0d: got %h expected %h", t, i, got_res[i], dig[i]); end
            end
            checks++;
            if (last_idx.size() != 1 || last_idx[0] != n - 1)
                begin failures++; $display("FAIL res_last case %0d: got %0d marks expected one at %0d", t, last_idx.size(), n - 1); end
            @(negedge clk);
            checks++;
            if ({req_rdy, dev.valid} !== 2'b10) begin failures++; $display("FAIL back_to_idle case %0d: got %b expected 10", t, {req_rdy, dev.valid}); end
        end
    endtask

    task automatic test_gap();
        make_stream(0, 128);
        run_txn(0, 32, 128, 0, 3);
        checks++;
        if (got.size() != 138) begin failures++; $display("FAIL gap_len: got %0d expected 138", got.size()); end
        else begin
            checks++;
            if (got_t[10] - got_t[9] != 1) begin failures++; $display("FAIL gap_conf_to_blk: got %0d expected 1", got_t[10] - got_t[9]); end
            checks++;
            if (got_t[73] - got_t[10] != 63) begin failures++; $display("FAIL gap_blk0_span: got %0d expected 63", got_t[73] - got_t[10]); end
            checks++;
            if (got_t[74] - got_t[73] != GAP + 1) begin failures++; $display("FAIL gap_idle: got %0d expected %0d", got_t[74] - got_t[73], GAP + 1); end
            checks++;
            if ({got[73][9:8], got[74][9:8]} !== {C_DATA, C_LAST})
                begin failures++; $display("FAIL gap_cmds: got %b expected 0110", {got[73][9:8], got[74][9:8]}); end
        end
        checks++;
        if (consumed != 128) begin failures++; $display("FAIL gap_consumed: got %0d expected 128", consumed); end
    endtask

    task automatic test_reset_mid();
        make_stream(0, 100);
        @(posedge clk); #1;
        req_v = 1'b1; kk = 0; nn = 32; ll = 100;
        @(posedge clk); #1;
        req_v = 1'b0; msg_v = 1'b1;
        repeat (30) begin @(posedge clk); #1; msg = 8'($urandom); end
        @(negedge clk);
        checks++;
        if ({dev.valid, msg_rdy} !== 2'b11) begin failures++; $display("FAIL mid_block_active: got %b expected 11", {dev.valid, msg_rdy}); end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_rdy, msg_rdy, dev.valid, dev.cmd, dev.data, res_v, res, res_last, err} !== 24'h800000)
            begin failures++; $display("FAIL reset_mid: got %h expected 800000",
                {req_rdy, msg_rdy, dev.valid, dev.cmd, dev.data, res_v, res, res_last, err}); end
        @(posedge clk); #1; reset = 1'b0; msg_v = 1'b0;
        make_stream(0, 5);
        run_txn(0, 2, 5, 0, 2);
        checks++;
        if (got.size() != 74 || got_res.size() != 2)
            begin failures++; $display("FAIL after_reset_txn: got %0d/%0d expected 74/2", got.size(), got_res.size()); end
        else begin
            checks++;
            if (got[10] !== {C_LAST, stream[0]}) begin failures++; $display("FAIL after_reset_byte: got %h expected %h", got[10], {C_LAST, stream[0]}); end
        end
    endtask

    task automatic test_timeout();
        make_stream(0, 10);
        build_exp(0, 4, 10);
        run_txn(0, 4, 10, 0, 150);
        @(negedge clk);
`ifdef BLAKE2_HOST_TIMEOUT_EN
        checks++;
        if (abort_cnt != 1 || abort_wc != TMO) begin failures++; $display("FAIL abort_cycle: got %0d at %0d expected 1 at %0d", abort_cnt, abort_wc, TMO); end
        checks++;
        if (got.size() != exp_q.size() + 1 || got[got.size() - 1] !== {C_ABORT, 8'h00})
            begin failures++; $display("FAIL abort_byte: got len %0d expected %0d", got.size(), exp_q.size() + 1); end
        checks++;
        if ({err, req_rdy, got_res.size() == 0} !== 3'b111) begin failures++; $display("FAIL abort_state: got %b expected 111", {err, req_rdy, got_res.size() == 0}); end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b expected 0", err); end
`else
        checks++;
        if (abort_cnt != 0 || got.size() != exp_q.size()) begin failures++; $display("FAIL no_abort: got %0d aborts len %0d expected 0 len %0d", abort_cnt, got.size(), exp_q.size()); end
        checks++;
        if (got_res.size() != 4 || err !== 1'b0) begin failures++; $display("FAIL long_wait_res: got %0d err %b expected 4 err 0", got_res.size(), err); end
`endif
    endtask

    initial begin
        reset = 1'b1; req_v = 1'b0; kk = '0; nn = '0; ll = '0; msg_v = 1'b0; msg = '0;
        dev.hash_finished = 1'b0; dev.hash = 8'h00;
        test_reset();
        test_stream();
        test_gap();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/blake2_host_drv.md
Name: blake2_host_drv

Overview:
- Host-side transmitter for the BLAKE2s byte-serial I/O protocol: the opposite end of the I/O interface in front of blake2s_hash256.
- Takes a config request (kk, nn, ll) plus a message byte stream from a local requester, serialises config and zero-padded 64-byte blocks onto valid/cmd/data, waits for hash_finished, then collects nn digest bytes.
- Used in FPGA host bridges and as the bench stimulus driver.

Parameters:
- COMPRESS_GAP, 24, idle cycles inserted after every non-final block so the core can compress.
- TIMEOUT_CYCLES, 4096, max cycles in WAIT_HASH. Only used with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_v_i  in  1  start request; accepted in IDLE only
- req_rdy_o  out  1  high in IDLE
- kk_i  in  8  key length, 0..32
- nn_i  in  8  digest length, 1..32
- ll_i  in  64  message length in bytes, excluding the key block
- msg_v_i  in  1  message byte valid
- msg_i  in  8  message byte
- msg_rdy_o  out  1  byte consumed this cycle when msg_v_i & msg_rdy_o
- valid_o  out  1  protocol byte valid
- cmd_o  out  2  00 CONF, 01 DATA, 10 LAST (any byte of final block), 11 ABORT
- data_o  out  8  protocol byte
- hash_finished_i  in  1  digest ready, level, from the device
- hash_i  in  8  digest byte, device advances one byte per cycle after finished
- res_v_o  out  1  digest byte valid
- res_o  out  8  digest byte, byte 0 first
- res_last_o  out  1  with the byte nn-1
- err_o  out  1  sticky timeout flag. Tied 0 without the optional feature.

Behaviour:
- Reset values: every output is 0 except req_rdy_o, which is 1. FSM is in IDLE.
- Block count: nblk = ceil(ll/64) + (kk!=0). If that is 0, nblk = 1 (a single all-zero block). The requester supplies the key as the first 64 stream bytes, zero-padded. Total stream bytes consumed = ll + 64*(kk!=0).
- IDLE: on req_v_i, latch kk/nn/ll, compute nblk (use a 58-bit block counter) and go to CONF.
- CONF: 10 consecutive cycles with valid_o=1, cmd=00. Bytes in order: kk, nn, ll[7:0] .. ll[63:56]. Then go to BLOCK.
- BLOCK: 6-bit byte index, 64 bytes per block.
  - cmd=LAST for every byte of block nblk-1; DATA otherwise.
  - While stream bytes remain, msg_rdy_o=1 and valid_o = msg_v_i; a stall inserts a bubble with valid_o=0.
  - Once the stream is exhausted, emit 0x00 padding each cycle with msg_rdy_o=0.
  - Index wraps at 63. After a non-final block go to GAP; after the final block go to WAIT_HASH.
- GAP: COMPRESS_GAP cycles with valid_o=0, then back to BLOCK.
- WAIT_HASH: wait for hash_finished_i=1. The first digest byte is hash_i in that same cycle.
- READ_HASH: res_v_o=1 for exactly nn consecutive cycles, with res_o registered from hash_i (1-cycle latency). res_last_o is high on byte nn-1. Then go to IDLE.
- msg_v_i outside BLOCK is ignored. req_v_i outside IDLE is ignored.
- reset asserted mid-operation: immediate return to IDLE. No ABORT byte is emitted; the device side is reset by its own reset.

Optional Feature:
- Macro BLAKE2_HOST_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_HASH.
  - Reaching TIMEOUT_CYCLES emits one cycle of valid_o=1, cmd=11, data=0x00, sets err_o (sticky until reset), and returns to IDLE with no res_v_o.
- Undefined: WAIT_HASH waits forever, err_o=0, and the counter is absent.

Decomposition:
- Shared package blake2_pkg: cmd encodings (CMD_CONF/DATA/LAST/ABORT), BLOCK_BYTES=64, CONF_BYTES=10, MAX_NN=32, MAX_KK=32.
- One sub-module, blake2_host_blkcnt: computes nblk from ll/kk and tracks remaining stream bytes. The FSM stays in the top block.

Test Plan:
- kk=0, nn=32, ll=3, stream "abc":
  - CONF bytes 00 20 03 00 00 00 00 00 00 00.
  - Then one LAST block: 61 63 62… no, 61 62 63 followed by 61 bytes of 0x00.
  - Device model returns the digest; res bytes are 50 8C 5E 8C … 86 67 59 82; res_last_o on byte 31.
- ll=0, kk=0, nn=32:
  - Exactly one LAST block of 64 zeros.
  - Digest 69 21 7A 30 … ; 32 res bytes.
- ll=128, kk=0:
  - Block 0 is DATA, then exactly COMPRESS_GAP idle cycles, then block 1 LAST.
  - No padding bytes; msg_rdy_o low after byte 127.
- kk=16, ll=65, nn=16:
  - nblk=3; 129 bytes consumed; the last block carries 1 message byte plus 63 zeros.
  - 16 res bytes, then req_rdy_o=1.
- msg_v_i toggled every other cycle during BLOCK:
  - valid_o mirrors the bubbles and the byte index advances only on accepted bytes.
  - reset pulsed mid-block: all outputs return to reset values the next edge.
- With BLAKE2_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100, hash_finished_i held 0:
  - ABORT byte in cycle 100 of WAIT_HASH, err_o=1, no res_v_o.
